// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: fetch FSM encodings and
// the PC increment.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer for a fetched {instruction, pc+4} pair that could not
// enter IF/ID because ID was stalled.
module fetch_hold_buf
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc4,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            instr    <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus4 <= load_pc4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: req/ack fetch from instruction memory into IF/ID.
// Optional FETCH_PERF_CNT_EN adds the FS_WAIT_CNT memory-wait cycle counter.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             FS_CLK,
    input  logic             FS_RST,
    input  logic [WIDTH-1:0] FS_PC,
    output logic             FS_PC_EN,
    output logic             FS_IMEM_REQ,
    output logic [WIDTH-1:0] FS_IMEM_ADDR,
    input  logic             FS_IMEM_ACK,
    input  logic [WIDTH-1:0] FS_IMEM_RDATA,
    input  logic             FS_STALL,
    input  logic             FS_FLUSH,
    output logic [WIDTH-1:0] FS_INSTR,
    output logic [WIDTH-1:0] FS_PC_PLUS4,
    output logic             FS_VALID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      FS_WAIT_CNT
`endif
);

    fetch_state_t     state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] pc4;
    logic             hb_load, hb_clear, hb_valid;
    logic [WIDTH-1:0] hb_instr, hb_pc4;

    assign pc4 = FS_PC + WIDTH'(PC_INC);

    // In DROP the PC may already hold the redirect target, so the stale address
    // must come from addr_q to keep ADDR stable until the response arrives.
    assign FS_IMEM_REQ  = !FS_RST && (state == FETCH || state == DROP);
    assign FS_IMEM_ADDR = FS_RST ? '0 : (state == DROP ? addr_q : FS_PC);
    assign FS_PC_EN     = !FS_RST && (FS_FLUSH || (state == FETCH && FS_IMEM_ACK));

    assign hb_load  = state == FETCH && FS_IMEM_ACK && !FS_FLUSH && FS_STALL;
    assign hb_clear = state == HOLD && (FS_FLUSH || !FS_STALL);

    fetch_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
        .clk        (FS_CLK),
        .rst        (FS_RST),
        .load       (hb_load),
        .clear      (hb_clear),
        .load_instr (FS_IMEM_RDATA),
        .load_pc4   (pc4),
        .instr      (hb_instr),
        .pc_plus4   (hb_pc4),
        .valid      (hb_valid)
    );

    always_ff @(posedge FS_CLK) begin
        if (FS_RST) begin
            state       <= FETCH;
            addr_q      <= '0;
            FS_INSTR    <= '0;
            FS_PC_PLUS4 <= '0;
            FS_VALID    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    addr_q <= FS_PC;
                    if (FS_FLUSH) begin
                        FS_VALID <= 1'b0;
                        if (!FS_IMEM_ACK) state <= DROP;
                    end else if (FS_IMEM_ACK) begin
                        if (FS_STALL) begin
                            state <= HOLD;
                        end else begin
                            FS_INSTR    <= FS_IMEM_RDATA;
                            FS_PC_PLUS4 <= pc4;
                            FS_VALID    <= 1'b1;
                        end
                    end else if (!FS_STALL) begin
                        FS_VALID <= 1'b0;
                    end
                end
                HOLD: begin
                    if (FS_FLUSH) begin
                        FS_VALID <= 1'b0;
                        state    <= FETCH;
                    end else if (!FS_STALL) begin
                        FS_INSTR    <= hb_instr;
                        FS_PC_PLUS4 <= hb_pc4;
                        FS_VALID    <= hb_valid;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    if (FS_FLUSH || !FS_STALL) FS_VALID <= 1'b0;
                    if (FS_IMEM_ACK) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge FS_CLK) begin
        if (FS_RST)
            FS_WAIT_CNT <= '0;
        else if (FS_IMEM_REQ && !FS_IMEM_ACK && FS_WAIT_CNT != 32'hFFFF_FFFF)
            FS_WAIT_CNT <= FS_WAIT_CNT + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expected IF/ID contents go through a queue
// and are popped when the stage is due to present them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_en;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] wait_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(32)) dut (
        .FS_CLK        (clk),
        .FS_RST        (rst),
        .FS_PC         (pc),
        .FS_PC_EN      (pc_en),
        .FS_IMEM_REQ   (req),
        .FS_IMEM_ADDR  (addr),
        .FS_IMEM_ACK   (ack),
        .FS_IMEM_RDATA (rdata),
        .FS_STALL      (stall),
        .FS_FLUSH      (flush),
        .FS_INSTR      (instr),
        .FS_PC_PLUS4   (pc_plus4),
        .FS_VALID      (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FS_WAIT_CNT   (wait_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then check
    // registered outputs #1 after the rising edge.
    task automatic step(input logic [31:0] p, input logic a, input logic [31:0] d,
                        input logic st, input logic fl,
                        input logic e_req, input logic e_en, input logic [31:0] e_addr,
                        input logic e_valid, input logic push, input logic [31:0] p_instr,
                        input logic [31:0] p_pc4, input logic pop, input string tag);
        logic [63:0] e;
        @(negedge clk);
        pc = p; ack = a; rdata = d; stall = st; flush = fl;
        #1;
        chk({tag, ".req"}, {31'd0, req}, {31'd0, e_req});
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e_en});
        if (e_req) chk({tag, ".addr"}, addr, e_addr);
        if (push) sb.push_back({p_instr, p_pc4});
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
        if (pop) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, ".instr"}, instr, e[63:32]);
                chk({tag, ".pc4"}, pc_plus4, e[31:0]);
            end
        end
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step(32'h0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, "rst0");
        chk("rst0.addr", addr, 32'h0);
        chk("rst0.instr", instr, 32'h0);
        chk("rst0.pc4", pc_plus4, 32'h0);
        @(negedge clk); rst = 1'b0; ack = 1'b0;

        // same-cycle ACK stream
        step(32'h0, 1, 32'h11, 0, 0, 1, 1, 32'h0, 1, 1, 32'h11, 32'h4, 1, "s0");
        step(32'h4, 1, 32'h22, 0, 0, 1, 1, 32'h4, 1, 1, 32'h22, 32'h8, 1, "s1");
        step(32'h8, 1, 32'h33, 0, 0, 1, 1, 32'h8, 1, 1, 32'h33, 32'hC, 1, "s2");

        // ACK delayed 3 cycles at 0x40
        step(32'h40, 0, 32'h0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0, "d0");
        step(32'h40, 0, 32'h0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0, "d1");
        step(32'h40, 0, 32'h0, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0, "d2");
        step(32'h40, 1, 32'hAA, 0, 0, 1, 1, 32'h40, 1, 1, 32'hAA, 32'h44, 1, "d3");
`ifdef FETCH_PERF_CNT_EN
        chk("d3.wait_cnt", wait_cnt, 32'd3);
`endif

        // STALL on ACK of 0x8: buffer, drain, resume
        step(32'h4, 1, 32'h55, 0, 0, 1, 1, 32'h4, 1, 1, 32'h55, 32'h8, 1, "h0");
        step(32'h8, 1, 32'h66, 1, 0, 1, 1, 32'h8, 1, 1, 32'h66, 32'hC, 0, "h1");
        chk("h1.instr_kept", instr, 32'h55);
        step(32'hC, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, "h2");
        chk("h2.instr_kept", instr, 32'h55);
        chk("h2.pc4_kept", pc_plus4, 32'h8);
        step(32'hC, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, "h3");
        step(32'hC, 1, 32'h77, 0, 0, 1, 1, 32'hC, 1, 1, 32'h77, 32'h10, 1, "h4");

        // FLUSH with request at 0x20 outstanding
        step(32'h20, 0, 32'h0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, "f0");
        step(32'h20, 0, 32'h0, 0, 1, 1, 1, 32'h20, 0, 0, 0, 0, 0, "f1");
        step(32'h100, 0, 32'h0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, "f2");
        step(32'h100, 1, 32'hDEAD, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, "f3");
        step(32'h100, 1, 32'h88, 0, 0, 1, 1, 32'h100, 1, 1, 32'h88, 32'h104, 1, "f4");
`ifdef FETCH_PERF_CNT_EN
        chk("f4.wait_cnt", wait_cnt, 32'd6);
`endif

        // FLUSH + STALL while in HOLD
        step(32'h104, 1, 32'h99, 1, 0, 1, 1, 32'h104, 1, 0, 0, 0, 0, "fs0");
        step(32'h104, 0, 32'h0, 1, 1, 0, 1, 32'h0, 0, 0, 0, 0, 0, "fs1");
        step(32'h200, 1, 32'hAB, 0, 0, 1, 1, 32'h200, 1, 1, 32'hAB, 32'h204, 1, "fs2");

        // reset mid-wait, then wraparound fetch
        step(32'h300, 0, 32'h0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 0, 0, "r0");
        rst = 1'b1;
        step(32'h300, 1, 32'h5A, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, "r1");
        chk("r1.addr", addr, 32'h0);
        chk("r1.instr", instr, 32'h0);
        chk("r1.pc4", pc_plus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("r1.wait_cnt", wait_cnt, 32'd0);
`endif
        @(negedge clk); rst = 1'b0;
        step(32'hFFFF_FFFC, 1, 32'hCC, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'hCC, 32'h0, 1, "w0");
        step(32'h0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, "w1");

        chk("sb.leftover", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It sits directly downstream of the PC register: it consumes the current PC and issues requests to instruction memory over a req/ack handshake. It drives the PC register's enable and loads the IF/ID pipeline register. Variable memory latency, ID-stage stalls and branch/jump flushes are absorbed by a one-entry hold buffer and a three-state FSM.

## Interface
- WIDTH, 32, address/instruction width
- FS_CLK  in  1  clock, rising edge
- FS_RST  in  1  reset, synchronous, active-high
- FS_PC  in  WIDTH  current PC from the PC register output
- FS_PC_EN  out  1  enable to the PC register (advance or load redirect target)
- FS_IMEM_REQ  out  1  instruction memory request
- FS_IMEM_ADDR  out  WIDTH  request address
- FS_IMEM_ACK  in  1  one-cycle response strobe; may be high in the same cycle REQ rises
- FS_IMEM_RDATA  in  WIDTH  instruction, valid when ACK=1
- FS_STALL  in  1  hazard unit: hold IF/ID
- FS_FLUSH  in  1  ID redirect (taken branch/jump): discard fetched/in-flight work
- FS_INSTR  out  WIDTH  IF/ID instruction
- FS_PC_PLUS4  out  WIDTH  IF/ID PC+4
- FS_VALID  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- FSM states:
  - FETCH: request active.
  - HOLD: instruction buffered, no request.
  - DROP: waiting to discard a stale response.
- Registers:
  - addr_q: captures FS_PC every cycle in FETCH.
  - Hold buffer: {instr, pc+4}.
- FETCH:
  - Outputs: REQ=1, ADDR=FS_PC.
  - ACK & FLUSH: discard data; stay FETCH.
  - ACK & !FLUSH & !STALL: load IF/ID with {RDATA, FS_PC+4}; VALID←1; stay FETCH.
  - ACK & !FLUSH & STALL: IF/ID unchanged; load hold buffer with {RDATA, FS_PC+4}; go HOLD.
  - !ACK & FLUSH: go DROP.
  - !ACK & !FLUSH: if !STALL, VALID←0; stay FETCH.
- HOLD:
  - Outputs: REQ=0.
  - FLUSH: clear buffer; go FETCH.
  - !STALL: move buffer into IF/ID; VALID←1; go FETCH.
  - STALL: wait.
- DROP:
  - Outputs: REQ=1, ADDR=addr_q (the old address stays stable until ACK).
  - ACK: discard data; go FETCH.
  - If !STALL, VALID←0.
- FS_PC_EN = FLUSH | (state==FETCH & ACK). FS_PC_EN is combinational, so the PC advances in the ACK cycle.
- FLUSH has priority over STALL in every state.
- Whenever FLUSH=1, VALID←0 (IF/ID is flushed even under STALL).
- PC+4 is computed modulo 2^WIDTH: 0xFFFFFFFC yields 0x00000000.
- Reset (FS_RST=1 at a clock edge, including mid-request):
  - State→FETCH; VALID, INSTR, PC_PLUS4, addr_q and buffer→0.
  - REQ and PC_EN are forced to 0 while FS_RST=1.
  - A response arriving after reset is not tracked; memory is reset together with the core.

## Timing
- IF/ID outputs are registered and update on the edge ending the ACK cycle. Latency is 1 cycle from ACK to FS_VALID.
- Throughput is 1 instruction/cycle with a same-cycle-ACK memory and no stalls.
- REQ stays high, with ADDR stable, from assertion until the ACK cycle. The hold mechanisms differ by state:
  - FETCH: PC_EN=0 keeps FS_PC constant.
  - DROP: addr_q is held.
- The FLUSH cycle always has PC_EN=1, so the PC register loads the redirect target on that edge.
- HOLD→FETCH: the new request starts in the cycle after the buffer drains.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds output FS_WAIT_CNT (32 bits, reset 0). It increments each cycle where REQ=1 & ACK=0 (FETCH or DROP) and saturates at 0xFFFFFFFF.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - State encodings: FETCH=2'd0, HOLD=2'd1, DROP=2'd2.
  - PC_INC=4.
- The hold buffer is a natural sub-module, fetch_hold_buf: a one-entry register with load/clear/valid.

## Test plan
- Same-cycle ACK, PC sequence 0x0,0x4,0x8 with RDATA 0x11,0x22,0x33: FS_PC_EN high every cycle; FS_INSTR=0x11,0x22,0x33 on consecutive cycles, with FS_PC_PLUS4=0x4,0x8,0xC; VALID=1 throughout.
- ACK delayed 3 cycles at PC 0x40:
  - REQ and ADDR=0x40 are held for 4 cycles, with PC_EN=0 until ACK.
  - VALID=0 during the wait.
  - The cycle after ACK: INSTR=RDATA, PC_PLUS4=0x44.
  - With the macro: FS_WAIT_CNT=3.
- STALL=1 when the ACK for 0x8 arrives: state goes HOLD; IF/ID keeps the 0x4 instruction. STALL drops two cycles later: IF/ID loads the 0x8 instruction, and REQ resumes the following cycle.
- FLUSH while the request at 0x20 is outstanding:
  - PC_EN=1 in the FLUSH cycle; state goes DROP.
  - ADDR stays 0x20 until ACK; the data is discarded and VALID stays 0.
  - FETCH then issues the target address.
- FLUSH and STALL together in HOLD: buffer cleared; VALID←0; state goes FETCH; PC_EN=1.
- FS_RST asserted mid-wait and FS_PC=0xFFFFFFFC fetch:
  - During reset: REQ=0, VALID=0 and all outputs 0.
  - After release, the fetch at 0xFFFFFFFC gives PC_PLUS4=0x00000000.
